// File: rtl/logic_unit_pkg.sv
// Shared definitions for the logic-unit arbiter slice: opcode encoding,
// FSM state encoding, requester count and the round-robin step helper.
package logic_unit_pkg;

  localparam int NREQ = 3;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_PASS = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Next requester index in round-robin order, wrapping 2 -> 0.
  function automatic logic [1:0] rrNext(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/logic_unit_arbiter_if.sv
// Request/grant/result bundle between the three requesters and the arbiter.
// The master side is the requester cluster; the slave side is the arbiter.
interface logic_unit_arbiter_if
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 1
);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] a_in;
  logic [NREQ*WIDTH-1:0] b_in;
  logic [2*NREQ-1:0]     op_in;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      y_out;
  logic [1:0]            y_id;
  logic                  y_valid;
  logic                  busy;

  modport master (
    output req, a_in, b_in, op_in,
    input  gnt, y_out, y_id, y_valid, busy
  );

  modport slave (
    input  req, a_in, b_in, op_in,
    output gnt, y_out, y_id, y_valid, busy
  );

endinterface

// File: rtl/logic_unit_alu.sv
// Combinational logic unit shared by all requesters: AND / OR / XOR / pass A.
module logic_unit_alu
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [1:0]       op_i,
  output logic [WIDTH-1:0] y_o
);

  // Opcode decode; every encoding is used, pass-A doubles as the default.
  always_comb begin
    y_o = a_i;
    case (op_i)
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_PASS: y_o = a_i;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin scheduler for one registered logic unit shared by three
// requesters. A grant captures the winner's operands, the following cycle
// computes and publishes a tagged result, and that result cycle can already
// grant the next requester, giving one operation every two cycles.
// Optional per-requester grant counters: define LOGIC_UNIT_ARB_STATS_EN.
module logic_unit_arbiter
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic clk,
  input  logic rst,
  logic_unit_arbiter_if.slave bus
`ifdef LOGIC_UNIT_ARB_STATS_EN
  ,
  output logic [8*NREQ-1:0] grant_cnt
`endif
);

  state_e           state_q, state_d;
  logic [1:0]       last_q, last_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [1:0]       id_q, id_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [1:0]       yId_q, yId_d;
  logic             yValid_q, yValid_d;
  logic             busy_q, busy_d;

  logic [1:0]       cand0, cand1;
  logic             winFound;
  logic [1:0]       winId;
  logic [WIDTH-1:0] aluY;

  logic_unit_alu #(.WIDTH(WIDTH)) u_alu (
    .a_i  (a_q),
    .b_i  (b_q),
    .op_i (op_q),
    .y_o  (aluY)
  );

  // Round-robin search starting just after the last winner.
  always_comb begin
    cand0    = rrNext(last_q);
    cand1    = rrNext(cand0);
    winFound = 1'b1;
    winId    = last_q;
    if (bus.req[cand0])       winId = cand0;
    else if (bus.req[cand1])  winId = cand1;
    else if (bus.req[last_q]) winId = last_q;
    else                      winFound = 1'b0;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: IDLE and RESP both arbitrate, EXEC always moves to RESP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = winFound ? S_EXEC : S_IDLE;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  state_d = winFound ? S_EXEC : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the capture and output registers for the current state.
  always_comb begin
    last_d   = last_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    id_d     = id_q;
    gnt_d    = '0;
    y_d      = y_q;
    yId_d    = yId_q;
    yValid_d = 1'b0;
    busy_d   = (state_d != S_IDLE);
    case (state_q)
      S_IDLE, S_RESP: begin
        if (winFound) begin
          last_d       = winId;
          id_d         = winId;
          a_d          = bus.a_in[winId*WIDTH +: WIDTH];
          b_d          = bus.b_in[winId*WIDTH +: WIDTH];
          op_d         = bus.op_in[winId*2 +: 2];
          gnt_d[winId] = 1'b1;
        end
      end
      S_EXEC: begin
        y_d      = aluY;
        yId_d    = id_q;
        yValid_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath and output registers; reset drops any captured transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q   <= 2'd2;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      id_q     <= '0;
      gnt_q    <= '0;
      y_q      <= '0;
      yId_q    <= '0;
      yValid_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      last_q   <= last_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      id_q     <= id_d;
      gnt_q    <= gnt_d;
      y_q      <= y_d;
      yId_q    <= yId_d;
      yValid_q <= yValid_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.y_out   = y_q;
  assign bus.y_id    = yId_q;
  assign bus.y_valid = yValid_q;
  assign bus.busy    = busy_q;

`ifdef LOGIC_UNIT_ARB_STATS_EN
  logic [NREQ-1:0][7:0] cnt_q;

  // Saturating per-requester grant counters, bumped once per grant pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (gnt_q[i] && (cnt_q[i] != 8'hFF)) cnt_q[i] <= cnt_q[i] + 8'd1;
      end
    end
  end

  assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter (WIDTH = 4). Expected results are
// queued when a request is driven and popped whenever y_valid appears.
// The grant-counter scenario runs only when LOGIC_UNIT_ARB_STATS_EN is defined.
module tb_logic_unit_arbiter;
  import logic_unit_pkg::*;

  localparam int WIDTH = 4;

  typedef struct packed {
    logic [1:0]       id;
    logic [WIDTH-1:0] y;
  } result_t;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  int      checks = 0;
  int      errors = 0;
  result_t expQ[$];
  result_t mon;

  logic_unit_arbiter_if #(.WIDTH(WIDTH)) bus ();

`ifdef LOGIC_UNIT_ARB_STATS_EN
  logic [23:0] grant_cnt;
`endif

  logic_unit_arbiter #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef LOGIC_UNIT_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Scoreboard: every result pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.y_valid === 1'b1) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_result got id=%0d y=%b want no result", bus.y_id, bus.y_out);
      end else begin
        mon = expQ.pop_front();
        if (bus.y_id !== mon.id || bus.y_out !== mon.y) begin
          errors++;
          $display("[TB] FAIL result got id=%0d y=%b want id=%0d y=%b", bus.y_id, bus.y_out, mon.id, mon.y);
        end
      end
    end
  end

  // Load one requester's operand slices.
  task automatic setOperands(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic [1:0] op);
    bus.a_in[id*WIDTH +: WIDTH] = a;
    bus.b_in[id*WIDTH +: WIDTH] = b;
    bus.op_in[id*2 +: 2]        = op;
  endtask

  // Two-cycle reset; any result still owed by the previous scenario is a loss.
  task automatic applyReset();
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL lost_results got %0d pending want 0", expQ.size());
    end
    expQ.delete();
    rst     = 1'b1;
    bus.req = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // All outputs must be zero straight out of reset.
  task automatic test_reset();
    bus.a_in  = '0;
    bus.b_in  = '0;
    bus.op_in = '0;
    applyReset();
    checks++;
    if ({bus.gnt, bus.y_out, bus.y_id, bus.y_valid, bus.busy} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got gnt=%b y=%b id=%0d v=%b busy=%b want all 0",
               bus.gnt, bus.y_out, bus.y_id, bus.y_valid, bus.busy);
    end
  endtask

  // One AND request: grant in cycle 1, result in cycle 2, then idle with held result.
  task automatic test_single();
    applyReset();
    setOperands(0, 4'b0001, 4'b0001, OP_AND);
    expQ.push_back(result_t'{id: 2'd0, y: 4'b0001});
    bus.req = 3'b001;
    @(negedge clk);
    checks++;
    if (bus.gnt !== 3'b001 || bus.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_grant got gnt=%b busy=%b want gnt=001 busy=1", bus.gnt, bus.busy);
    end
    bus.req = 3'b000;
    @(negedge clk);
    checks++;
    if (bus.y_valid !== 1'b1 || bus.gnt !== 3'b000 || bus.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_resp got v=%b gnt=%b busy=%b want v=1 gnt=000 busy=1",
               bus.y_valid, bus.gnt, bus.busy);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.y_valid !== 1'b0 || bus.y_out !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL single_idle got busy=%b v=%b y=%b want busy=0 v=0 y=0001",
               bus.busy, bus.y_valid, bus.y_out);
    end
  endtask

  // Three simultaneous requests served 0,1,2 with one result every two cycles.
  task automatic test_all_three();
    logic [2:0] expG [6] = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000};
    applyReset();
    setOperands(0, 4'b0001, 4'b0000, OP_AND);
    setOperands(1, 4'b0001, 4'b0000, OP_OR);
    setOperands(2, 4'b0001, 4'b0000, OP_XOR);
    expQ.push_back(result_t'{id: 2'd0, y: 4'b0000});
    expQ.push_back(result_t'{id: 2'd1, y: 4'b0001});
    expQ.push_back(result_t'{id: 2'd2, y: 4'b0001});
    bus.req = 3'b111;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (bus.gnt !== expG[c] || bus.y_valid !== logic'(c % 2)) begin
        errors++;
        $display("[TB] FAIL all3_cycle%0d got gnt=%b v=%b want gnt=%b v=%0d",
                 c + 1, bus.gnt, bus.y_valid, expG[c], c % 2);
      end
      bus.req = bus.req & ~bus.gnt;
    end
    bus.req = 3'b000;
    @(negedge clk);
  endtask

  // Persistent requester 1 must not lock out requester 2; then all three persist.
  task automatic test_fairness();
    logic [2:0] expA [8]  = '{3'b010, 3'b000, 3'b100, 3'b000, 3'b010, 3'b000, 3'b010, 3'b000};
    logic [2:0] expB [12] = '{3'b100, 3'b000, 3'b001, 3'b000, 3'b010, 3'b000,
                              3'b100, 3'b000, 3'b001, 3'b000, 3'b010, 3'b000};
    applyReset();
    setOperands(0, 4'b0100, 4'b1111, OP_PASS);
    setOperands(1, 4'b0001, 4'b0000, OP_OR);
    setOperands(2, 4'b0011, 4'b0001, OP_XOR);
    expQ.push_back(result_t'{id: 2'd1, y: 4'b0001});
    expQ.push_back(result_t'{id: 2'd2, y: 4'b0010});
    expQ.push_back(result_t'{id: 2'd1, y: 4'b0001});
    expQ.push_back(result_t'{id: 2'd1, y: 4'b0001});
    bus.req = 3'b110;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (bus.gnt !== expA[c]) begin
        errors++;
        $display("[TB] FAIL fair1_cycle%0d got gnt=%b want %b", c + 1, bus.gnt, expA[c]);
      end
      bus.req = bus.req & ~(bus.gnt & 3'b100);
    end
    bus.req = 3'b000;
    @(negedge clk);
    // last winner is requester 1, so the rotation resumes at 2
    for (int k = 0; k < 2; k++) begin
      expQ.push_back(result_t'{id: 2'd2, y: 4'b0010});
      expQ.push_back(result_t'{id: 2'd0, y: 4'b0100});
      expQ.push_back(result_t'{id: 2'd1, y: 4'b0001});
    end
    bus.req = 3'b111;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++;
      if (bus.gnt !== expB[c]) begin
        errors++;
        $display("[TB] FAIL fair3_cycle%0d got gnt=%b want %b", c + 1, bus.gnt, expB[c]);
      end
      if (c == 10) bus.req = 3'b000;
    end
    @(negedge clk);
  endtask

  // Reset during EXEC drops the transaction and restores requester-0 priority.
  task automatic test_reset_mid();
    logic [2:0] expG [6] = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000};
    applyReset();
    setOperands(1, 4'b1010, 4'b0110, OP_PASS);
    expQ.push_back(result_t'{id: 2'd1, y: 4'b1010});
    bus.req = 3'b010;
    @(negedge clk);
    bus.req = 3'b000;
    @(negedge clk);
    @(negedge clk);
    setOperands(0, 4'b1111, 4'b1111, OP_AND);
    bus.req = 3'b001;
    @(negedge clk);
    checks++;
    if (bus.gnt !== 3'b001) begin
      errors++;
      $display("[TB] FAIL midrst_grant got gnt=%b want 001", bus.gnt);
    end
    rst     = 1'b1;
    bus.req = 3'b000;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({bus.gnt, bus.y_out, bus.y_id, bus.y_valid, bus.busy} !== '0) begin
      errors++;
      $display("[TB] FAIL midrst_outputs got gnt=%b y=%b id=%0d v=%b busy=%b want all 0",
               bus.gnt, bus.y_out, bus.y_id, bus.y_valid, bus.busy);
    end
    setOperands(0, 4'b0001, 4'b0000, OP_PASS);
    setOperands(1, 4'b0010, 4'b0000, OP_PASS);
    setOperands(2, 4'b0100, 4'b0000, OP_PASS);
    expQ.push_back(result_t'{id: 2'd0, y: 4'b0001});
    expQ.push_back(result_t'{id: 2'd1, y: 4'b0010});
    expQ.push_back(result_t'{id: 2'd2, y: 4'b0100});
    bus.req = 3'b111;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (bus.gnt !== expG[c]) begin
        errors++;
        $display("[TB] FAIL midrst_order_cycle%0d got gnt=%b want %b", c + 1, bus.gnt, expG[c]);
      end
      bus.req = bus.req & ~bus.gnt;
    end
    bus.req = 3'b000;
    @(negedge clk);
  endtask

  // Requester 0 keeps requesting and changes opcode after each grant: PASS, XOR, AND, OR.
  task automatic test_back_to_back();
    logic [1:0]       ops [4] = '{OP_PASS, OP_XOR, OP_AND, OP_OR};
    logic [WIDTH-1:0] res [4] = '{4'b1010, 4'b1100, 4'b0010, 4'b1110};
    applyReset();
    setOperands(0, 4'b1010, 4'b0110, ops[0]);
    expQ.push_back(result_t'{id: 2'd0, y: res[0]});
    bus.req = 3'b001;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (bus.gnt !== 3'b001) begin
        errors++;
        $display("[TB] FAIL b2b_grant%0d got gnt=%b want 001", k, bus.gnt);
      end
      if (k < 3) begin
        bus.op_in[1:0] = ops[k+1];
        expQ.push_back(result_t'{id: 2'd0, y: res[k+1]});
      end else begin
        bus.req = 3'b000;
      end
      @(negedge clk);
      checks++;
      if (bus.y_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL b2b_valid%0d got v=%b want 1", k, bus.y_valid);
      end
    end
    @(negedge clk);
  endtask

`ifdef LOGIC_UNIT_ARB_STATS_EN
  // 300 grants to requester 0 saturate its counter and leave the others at 0.
  task automatic test_stats();
    int n = 0;
    applyReset();
    checks++;
    if (grant_cnt !== 24'd0) begin
      errors++;
      $display("[TB] FAIL stats_reset got %h want 000000", grant_cnt);
    end
    setOperands(0, 4'b0101, 4'b0000, OP_PASS);
    bus.req = 3'b001;
    for (int c = 0; c < 1000 && n < 300; c++) begin
      @(negedge clk);
      if (bus.gnt[0] === 1'b1) begin
        n++;
        expQ.push_back(result_t'{id: 2'd0, y: 4'b0101});
        if (n == 300) bus.req = 3'b000;
      end
    end
    bus.req = 3'b000;
    checks++;
    if (n != 300) begin
      errors++;
      $display("[TB] FAIL stats_timeout got %0d grants want 300", n);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (grant_cnt[7:0] !== 8'd255 || grant_cnt[23:8] !== 16'd0) begin
      errors++;
      $display("[TB] FAIL stats_count got %h want 0000ff", grant_cnt);
    end
  endtask
`endif

  // Scenario sequence and summary.
  initial begin
    bus.req   = '0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    bus.op_in = '0;
    test_reset();
    test_single();
    test_all_three();
    test_fairness();
    test_reset_mid();
    test_back_to_back();
`ifdef LOGIC_UNIT_ARB_STATS_EN
    test_stats();
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL final_drain got %0d pending want 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Time-shares one registered logic unit (AND / OR / XOR / pass) among three requesters using a round-robin req/gnt handshake. It sits beside the existing gate-level datapath. Instead of instantiating one gate per operand pair, the top level routes all operand pairs through this block and gets back one tagged result at a time. It is the controller and scheduler for that shared resource.

## Interface
Parameters:
- WIDTH, default 1: operand and result width in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  3  request bit `i` for requester `i`; held high until `gnt[i]` is seen.
- a_in  input  3*WIDTH  operand A; requester `i` drives bits `[i*WIDTH +: WIDTH]`.
- b_in  input  3*WIDTH  operand B; same slicing as `a_in`.
- op_in  input  6  opcode; requester `i` drives bits `[2i +: 2]`. Encoding: 00 AND, 01 OR, 10 XOR, 11 pass A.
- gnt  output  3  one-hot pulse, one cycle long; its operands have been captured.
- y_out  output  WIDTH  result.
- y_id  output  2  index of the requester that owns `y_out`.
- y_valid  output  1  one-cycle pulse; `y_out` and `y_id` are valid.
- busy  output  1  high when the state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any `req` bit is high, arbitrate, capture the winner's `a`, `b`, `op` and `id` into registers, set `gnt` to the winner's one-hot value, and go to EXEC.
  - Otherwise stay in IDLE.
- EXEC:
  - Compute `op(a_r, b_r)` into `y_out`, load `y_id`, set `y_valid`, and go to RESP.
  - No arbitration happens in this state.
- RESP:
  - `y_valid` is high for this one cycle.
  - RESP arbitrates exactly as IDLE does. If any `req` bit is high, capture the winner and go to EXEC; otherwise go to IDLE.
- Round robin:
  - A pointer `last` holds the most recent winner.
  - Search order is `last+1`, `last+2`, `last` (mod 3).
  - The first requester found with `req` high wins, and `last` is updated to that winner.
- `y_out` and `y_id` hold their values until the next EXEC overwrites them.
- Reset values:
  - State is IDLE.
  - `gnt`, `y_out`, `y_id`, `y_valid` and `busy` are 0.
  - `last` is 2, so requester 0 has top priority after reset.
- Reset mid-operation: any captured transaction is discarded. No `y_valid` and no `gnt` are issued for it.
- Requester rule: `req[i]` must be low by the edge that ends the cycle after `gnt[i]` (the RESP cycle). A `req` still high at that edge is treated as a new request.
- Requests for `req` bits outside the winner are not lost. They wait with no timeout.

## Timing
- Cycle 0 (IDLE or RESP): `req` is sampled.
- Cycle 1 (EXEC): `gnt` is high.
- Cycle 2 (RESP): `y_valid` is high.
- Latency from request to result is 2 cycles.
- Sustained throughput is one operation every 2 cycles: EXEC and RESP alternate while requests are pending.
- `busy` is registered. It is high in EXEC and RESP.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- Macro `LOGIC_UNIT_ARB_STATS_EN`.
- When defined:
  - Adds output `grant_cnt` (24 bits): three 8-bit counters at `[8i +: 8]`, one per requester.
  - Each counter increments on every `gnt[i]` pulse and saturates at 255.
  - Synchronous reset clears all counters to 0.
- When undefined:
  - The `grant_cnt` port and its counters do not exist.
  - All other behaviour is identical.

## Structure
- Shared package `logic_unit_pkg` holds:
  - the opcode constants `OP_AND`, `OP_OR`, `OP_XOR`, `OP_PASS`;
  - the FSM state encoding `S_IDLE`, `S_EXEC`, `S_RESP`;
  - `NREQ = 3`.
- One sub-module, `logic_unit_alu`: purely combinational. It takes `a`, `b` and `op` and produces `y`, and holds the opcode decode.
- Arbitration, the FSM and the registers stay in `logic_unit_arbiter`.

## Test plan
- Single request: after reset, pulse `req = 001` with `a0 = 1`, `b0 = 1`, `op0 = 00`.
  - Expect `gnt = 001` in cycle 1.
  - Expect `y_valid = 1`, `y_out = 1`, `y_id = 0` in cycle 2.
- All three requesting: hold `req = 111` (each requester drops after its grant). Operands are `a = 1`, `b = 0`; opcodes `op0 = 00`, `op1 = 01`, `op2 = 10`.
  - Expect grants in order 0, 1, 2 on cycles 1, 3, 5.
  - Expect results 0, 1, 1 on cycles 2, 4, 6.
- Fairness: requester 1 holds `req` continuously and re-asserts after every grant; requester 2 requests once.
  - Expect requester 2 to win at the first arbitration after requester 1's first grant.
  - Expect no requester to be starved beyond 2 grants.
- Reset mid-operation: assert `rst` for 1 cycle during EXEC.
  - Expect no `y_valid`.
  - Expect state IDLE and all outputs 0 on the next cycle.
  - Expect requester 0 to win the next `req = 111`.
- Pass opcode with WIDTH = 4: `a = 1010`, `b = 0110`, `op = 11`.
  - Expect `y_out = 1010`.
  - The same operands with `op = 10` give `1100`.
- With `LOGIC_UNIT_ARB_STATS_EN`: grant requester 0 three hundred times.
  - Expect `grant_cnt[7:0] = 255` and the other counters 0.
